// File: rtl/design1_wrapper_pkg.sv
// Shared definitions for the design1 AXI4 burst master / memory slave pair.
package design1_wrapper_pkg;

    localparam int ADDR_W_DEFAULT    = 32;
    localparam int DATA_W_DEFAULT    = 64;
    localparam int MEM_DEPTH_DEFAULT = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } master_state_e;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // Larger encoding is the more severe response (OKAY < EXOKAY < SLVERR < DECERR).
    function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/design1_wrapper_axi_mem_slave.sv
// AXI4 memory slave: MEM_DEPTH data words, byte strobes, aliasing on upper address bits.
module axi_mem_slave
    import design1_wrapper_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_LO = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {SL_IDLE, SL_WRITE, SL_BRESP, SL_READ} slave_state_e;

    slave_state_e           state;
    logic [DATA_W-1:0]      mem [MEM_DEPTH];
    logic [ADDR_W-1:0]      addr_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [7:0]             len_q;
    logic [7:0]             cnt_q;
    logic                   mem_we;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_LO +: IDX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + (ADDR_W'(1) << size);
    endfunction

    assign bresp  = RESP_OKAY;
    assign rresp  = RESP_OKAY;
    assign mem_we = (state == SL_WRITE) && wvalid && wready;

    // Memory contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= SL_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                SL_IDLE: begin
                    if (awready && awvalid) begin
                        awready <= 1'b0;
                        addr_q  <= awaddr;
                        size_q  <= awsize;
                        burst_q <= awburst;
                        len_q   <= awlen;
                        cnt_q   <= '0;
                        wready  <= 1'b1;
                        state   <= SL_WRITE;
                    end else if (arready && arvalid) begin
                        arready <= 1'b0;
                        rdata   <= mem[word_idx(araddr)];
                        addr_q  <= next_addr(araddr, arsize, arburst);
                        size_q  <= arsize;
                        burst_q <= arburst;
                        len_q   <= arlen;
                        cnt_q   <= '0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        state   <= SL_READ;
                    end else if (awvalid) begin
                        awready <= 1'b1;
                    end else if (arvalid) begin
                        arready <= 1'b1;
                    end
                end
                SL_WRITE: begin
                    if (wvalid) begin
                        addr_q <= next_addr(addr_q, size_q, burst_q);
                        cnt_q  <= cnt_q + 8'd1;
                        if (wlast || cnt_q == len_q) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            state  <= SL_BRESP;
                        end
                    end
                end
                SL_BRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= SL_IDLE;
                    end
                end
                // Next word is fetched while the current one is accepted, so beats stream back-to-back.
                SL_READ: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= SL_IDLE;
                        end else begin
                            rdata  <= mem[word_idx(addr_q)];
                            addr_q <= next_addr(addr_q, size_q, burst_q);
                            cnt_q  <= cnt_q + 8'd1;
                            rlast  <= ((cnt_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= SL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/design1_wrapper_master.sv
// AXI4 burst master driven by a simple start/stall user handshake.
// Single-ID master (ID 0); ID wires are omitted since the internal slave is its only peer.
module axi_burst_master
    import design1_wrapper_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  user_start,
    input  logic                  user_w_r,
    input  logic [ADDR_W-1:0]     user_addr_in,
    input  logic [7:0]            user_burst_len_in,
    input  logic [DATA_W/8-1:0]   user_data_strb,
    input  logic [DATA_W-1:0]     user_data_in,
    output logic                  user_stall_w_data,
    output logic [DATA_W-1:0]     user_data_out,
    output logic                  user_data_out_en,
    output logic                  user_free,
    output logic [1:0]            user_status,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [2:0] AXI_SIZE = axi_size(DATA_W);

    master_state_e          state;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             len_q;
    logic [7:0]             beat_q;
    logic [DATA_W/8-1:0]    strb_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   load_q;
    logic [1:0]             worst_q;

    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXI_SIZE;
    assign awburst = BURST_INCR;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXI_SIZE;
    assign arburst = BURST_INCR;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state             <= ST_IDLE;
            user_free         <= 1'b1;
            user_stall_w_data <= 1'b0;
            user_data_out_en  <= 1'b0;
            user_data_out     <= '0;
            user_status       <= RESP_OKAY;
            awvalid           <= 1'b0;
            wvalid            <= 1'b0;
            wlast             <= 1'b0;
            bready            <= 1'b0;
            arvalid           <= 1'b0;
            rready            <= 1'b0;
            addr_q            <= '0;
            len_q             <= '0;
            beat_q            <= '0;
            strb_q            <= '0;
            wdata_q           <= '0;
            load_q            <= 1'b0;
            worst_q           <= RESP_OKAY;
        end else begin
            user_data_out_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (user_start) begin
                        addr_q    <= user_addr_in;
                        len_q     <= user_burst_len_in;
                        strb_q    <= user_data_strb;
                        beat_q    <= '0;
                        load_q    <= 1'b0;
                        user_free <= 1'b0;
                        if (user_w_r) begin
                            arvalid <= 1'b1;
                            state   <= ST_RADDR;
                        end else begin
                            wdata_q           <= user_data_in;
                            user_stall_w_data <= 1'b1;
                            awvalid           <= 1'b1;
                            state             <= ST_WADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= (len_q == 8'd0);
                        state   <= ST_WDATA;
                    end
                end
                // Each accepted beat opens a one-cycle stall-low window; the next word is taken at its closing edge.
                ST_WDATA: begin
                    if (wvalid && wready) begin
                        wvalid            <= 1'b0;
                        user_stall_w_data <= 1'b0;
                        if (wlast) begin
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= ST_WRESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            load_q <= 1'b1;
                        end
                    end else if (load_q) begin
                        wdata_q           <= user_data_in;
                        wvalid            <= 1'b1;
                        wlast             <= (beat_q == len_q);
                        load_q            <= 1'b0;
                        user_stall_w_data <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        bready            <= 1'b0;
                        user_status       <= bresp;
                        user_free         <= 1'b1;
                        user_stall_w_data <= 1'b0;
                        state             <= ST_IDLE;
                    end else begin
                        user_stall_w_data <= 1'b1;
                    end
                end
                ST_RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        worst_q <= RESP_OKAY;
                        state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid) begin
                        user_data_out    <= rdata;
                        user_data_out_en <= 1'b1;
                        worst_q          <= worse_resp(worst_q, rresp);
                        if (rlast) begin
                            user_status <= worse_resp(worst_q, rresp);
                            rready      <= 1'b0;
                            user_free   <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/design1_wrapper.sv
// Top: AXI4 burst master wired to an internal AXI4 memory slave; only user ports leave the block.
module design1_wrapper
    import design1_wrapper_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                  aclk_0,
    input  logic                  areset_0,
    input  logic                  user_start_0,
    input  logic                  user_w_r_0,
    input  logic [ADDR_W-1:0]     user_addr_in_0,
    input  logic [7:0]            user_burst_len_in_0,
    input  logic [DATA_W/8-1:0]   user_data_strb_0,
    input  logic [DATA_W-1:0]     user_data_in_0,
    output logic                  user_stall_w_data_0,
    output logic [DATA_W-1:0]     user_data_out_0,
    output logic                  user_data_out_en_0,
    output logic                  user_free_0,
    output logic [1:0]            user_status_0
);

    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst;
    logic                awvalid, awready, arvalid, arready;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;
    logic [1:0]          bresp, rresp;
    logic                bvalid, bready;
    logic                rlast, rvalid, rready;

    axi_burst_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_master (
        .aclk              (aclk_0),
        .areset            (areset_0),
        .user_start        (user_start_0),
        .user_w_r          (user_w_r_0),
        .user_addr_in      (user_addr_in_0),
        .user_burst_len_in (user_burst_len_in_0),
        .user_data_strb    (user_data_strb_0),
        .user_data_in      (user_data_in_0),
        .user_stall_w_data (user_stall_w_data_0),
        .user_data_out     (user_data_out_0),
        .user_data_out_en  (user_data_out_en_0),
        .user_free         (user_free_0),
        .user_status       (user_status_0),
        .awaddr            (awaddr),
        .awlen             (awlen),
        .awsize            (awsize),
        .awburst           (awburst),
        .awvalid           (awvalid),
        .awready           (awready),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .wlast             (wlast),
        .wvalid            (wvalid),
        .wready            (wready),
        .bresp             (bresp),
        .bvalid            (bvalid),
        .bready            (bready),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    axi_mem_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .aclk    (aclk_0),
        .areset  (areset_0),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench: directed and random bursts checked against a byte-level memory model.
module tb_design1_wrapper;

    logic        aclk_0 = 1'b0;
    logic        areset_0;
    logic        user_start_0;
    logic        user_w_r_0;
    logic [31:0] user_addr_in_0;
    logic [7:0]  user_burst_len_in_0;
    logic [7:0]  user_data_strb_0;
    logic [63:0] user_data_in_0;
    logic        user_stall_w_data_0;
    logic [63:0] user_data_out_0;
    logic        user_data_out_en_0;
    logic        user_free_0;
    logic [1:0]  user_status_0;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model_mem [1024];
    logic [63:0] wr_words [$];
    logic [63:0] rd_words [$];
    logic [31:0] mix_addr [10];
    int          mix_len  [10];

    design1_wrapper dut (
        .aclk_0              (aclk_0),
        .areset_0            (areset_0),
        .user_start_0        (user_start_0),
        .user_w_r_0          (user_w_r_0),
        .user_addr_in_0      (user_addr_in_0),
        .user_burst_len_in_0 (user_burst_len_in_0),
        .user_data_strb_0    (user_data_strb_0),
        .user_data_in_0      (user_data_in_0),
        .user_stall_w_data_0 (user_stall_w_data_0),
        .user_data_out_0     (user_data_out_0),
        .user_data_out_en_0  (user_data_out_en_0),
        .user_free_0         (user_free_0),
        .user_status_0       (user_status_0)
    );

    always #5 aclk_0 = ~aclk_0;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_free"},     64'(user_free_0),         64'd1);
        checkOutput({tag, "_stall"},    64'(user_stall_w_data_0), 64'd0);
        checkOutput({tag, "_out_en"},   64'(user_data_out_en_0),  64'd0);
        checkOutput({tag, "_data_out"}, user_data_out_0,          64'd0);
        checkOutput({tag, "_status"},   64'(user_status_0),       64'd0);
    endtask

    task automatic fillWords(input int n, input bit zero);
        wr_words.delete();
        for (int i = 0; i < n; i++)
            wr_words.push_back(zero ? 64'd0 : {$urandom, $urandom});
    endtask

    // Reference: word index is the byte address divided by 8, modulo the memory depth.
    task automatic modelWrite(input logic [31:0] addr, input int len, input logic [7:0] strb);
        int base;
        int w;
        base = int'((addr >> 3) % 1024);
        for (int i = 0; i <= len; i++) begin
            w = (base + i) % 1024;
            for (int b = 0; b < 8; b++)
                if (strb[b]) model_mem[w][8*b +: 8] = wr_words[i][8*b +: 8];
        end
    endtask

    task automatic applyStimulus(input bit is_read, input logic [31:0] addr, input int len, input logic [7:0] strb);
        int cycles;
        int falls;
        int stall_in_read;
        bit prev_stall;
        bit done;
        cycles = 0;
        while (user_free_0 !== 1'b1 && cycles < 200) begin
            @(negedge aclk_0);
            cycles++;
        end
        checkOutput("free_before_start", 64'(user_free_0), 64'd1);
        user_start_0        = 1'b1;
        user_w_r_0          = is_read;
        user_addr_in_0      = addr;
        user_burst_len_in_0 = len[7:0];
        user_data_strb_0    = strb;
        user_data_in_0      = is_read ? {$urandom, $urandom} : wr_words[0];
        @(negedge aclk_0);
        user_start_0 = 1'b0;
        checkOutput("free_low_after_start", 64'(user_free_0), 64'd0);
        rd_words.delete();
        falls = 0;
        stall_in_read = 0;
        prev_stall = 1'b0;
        done = 1'b0;
        cycles = 0;
        while (!done && cycles < 4000) begin
            if (user_data_out_en_0 === 1'b1) rd_words.push_back(user_data_out_0);
            if (is_read && user_stall_w_data_0 !== 1'b0) stall_in_read++;
            if (prev_stall && user_stall_w_data_0 === 1'b0) begin
                falls++;
                if (falls <= len) user_data_in_0 = wr_words[falls];
            end
            prev_stall = (user_stall_w_data_0 === 1'b1);
            if (user_free_0 === 1'b1) done = 1'b1;
            else begin
                @(negedge aclk_0);
                cycles++;
            end
        end
        checkOutput("cmd_completes", 64'(done), 64'd1);
        if (is_read) begin
            checkOutput("read_beats", 64'(rd_words.size()), 64'(len + 1));
            checkOutput("stall_in_read", 64'(stall_in_read), 64'd0);
        end else begin
            checkOutput("stall_falls", 64'(falls), 64'(len + 1));
        end
        checkOutput("status", 64'(user_status_0), 64'd0);
    endtask

    task automatic runWrite(input logic [31:0] addr, input int len, input logic [7:0] strb);
        applyStimulus(1'b0, addr, len, strb);
        modelWrite(addr, len, strb);
    endtask

    task automatic runRead(input logic [31:0] addr, input int len);
        int base;
        logic [63:0] obs;
        applyStimulus(1'b1, addr, len, 8'h00);
        base = int'((addr >> 3) % 1024);
        for (int i = 0; i <= len; i++) begin
            obs = (i < rd_words.size()) ? rd_words[i] : 64'hx;
            checkOutput($sformatf("rd_%h_beat%0d", addr, i), obs, model_mem[(base + i) % 1024]);
        end
    endtask

    initial begin
        areset_0            = 1'b1;
        user_start_0        = 1'b0;
        user_w_r_0          = 1'b0;
        user_addr_in_0      = '0;
        user_burst_len_in_0 = '0;
        user_data_strb_0    = '0;
        user_data_in_0      = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;

        #1;
        checkReset("por");
        repeat (3) @(negedge aclk_0);
        checkReset("por_clocked");
        areset_0 = 1'b0;
        @(negedge aclk_0);

        // Single beat write/read.
        wr_words.delete();
        wr_words.push_back(64'h00000000F8F4F2F1);
        runWrite(32'h10000000, 0, 8'hFF);
        runRead(32'h10000000, 0);
        checkOutput("single_beat_value", rd_words.size() > 0 ? rd_words[0] : 64'hx, 64'h00000000F8F4F2F1);

        // 16-beat burst.
        fillWords(16, 1'b0);
        runWrite(32'h10000080, 15, 8'hFF);
        runRead(32'h10000080, 15);

        // Upper-half strobe over zeroed memory.
        fillWords(16, 1'b1);
        runWrite(32'h300010C0, 15, 8'hFF);
        fillWords(16, 1'b0);
        runWrite(32'h300010C0, 15, 8'hF0);
        runRead(32'h300010C0, 15);
        checkOutput("upper_strb_low_half", rd_words.size() > 0 ? 64'(rd_words[0][31:0]) : 64'hx, 64'd0);

        // Sparse byte strobes over known contents.
        fillWords(1, 1'b0);
        runWrite(32'h30001500, 0, 8'hFF);
        fillWords(1, 1'b0);
        runWrite(32'h30001540, 0, 8'hFF);
        fillWords(1, 1'b0);
        runWrite(32'h30001500, 0, 8'h01);
        fillWords(1, 1'b0);
        runWrite(32'h30001540, 0, 8'hAA);
        runRead(32'h30001500, 0);
        runRead(32'h30001540, 0);

        // Random mixed traffic inside a zeroed 256-word window, random upper bits exercise aliasing.
        fillWords(256, 1'b1);
        runWrite(32'h20000800, 255, 8'hFF);
        for (int k = 0; k < 10; k++) begin
            mix_addr[k] = ($urandom & 32'hFFFF_E000) | (32'h800 + ($urandom_range(0, 200) << 3));
            mix_len[k]  = $urandom_range(0, 15);
            fillWords(mix_len[k] + 1, 1'b0);
            runWrite(mix_addr[k], mix_len[k], 8'($urandom));
        end
        for (int k = 0; k < 10; k++) runRead(mix_addr[k], mix_len[k]);

        // Reset in the middle of a write burst.
        fillWords(16, 1'b0);
        user_start_0        = 1'b1;
        user_w_r_0          = 1'b0;
        user_addr_in_0      = 32'h40001800;
        user_burst_len_in_0 = 8'd15;
        user_data_strb_0    = 8'hFF;
        user_data_in_0      = wr_words[0];
        @(negedge aclk_0);
        user_start_0 = 1'b0;
        repeat (8) @(negedge aclk_0);
        checkOutput("busy_before_reset", 64'(user_free_0), 64'd0);
        #2 areset_0 = 1'b1;
        #1;
        checkReset("mid_burst");
        @(negedge aclk_0);
        areset_0 = 1'b0;
        @(negedge aclk_0);
        fillWords(4, 1'b0);
        runWrite(32'h40001800, 3, 8'hFF);
        runRead(32'h40001800, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/design1_wrapper.md
DESIGN1_WRAPPER -- requirements
Module: design1_wrapper

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 64, data width; MEM_DEPTH, default 1024, internal memory depth in DATA_W words.
REQ-002 SHALL have ports (clock and reset first):
- aclk_0  in  1  sole clock; all logic on its rising edge.
- areset_0  in  1  reset, asynchronous, active-high.
- user_start_0  in  1  one-cycle command strobe, sampled only while user_free_0=1.
- user_w_r_0  in  1  0=write, 1=read; sampled with start.
- user_addr_in_0  in  ADDR_W  byte start address, 8-byte aligned.
- user_burst_len_in_0  in  8  AXI LEN; beats = LEN+1.
- user_data_strb_0  in  DATA_W/8  byte strobe applied to every beat of a write.
- user_data_in_0  in  DATA_W  write data.
- user_stall_w_data_0  out  1  high = hold user_data_in_0; falling edge = present next word.
- user_data_out_0  out  DATA_W  read data.
- user_data_out_en_0  out  1  high one cycle per valid read beat.
- user_free_0  out  1  master idle, ready for a command.
- user_status_0  out  2  response (AXI BRESP/RRESP encoding) of last completed command.

Function
REQ-003 SHALL contain an AXI4 burst master connected to an internal AXI4 memory slave; only the user ports are external.
REQ-004 Master SHALL issue INCR bursts, SIZE=log2(DATA_W/8) (3 for 64-bit), ID=0, LEN=user_burst_len_in_0.
REQ-005 Master FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA; write path IDLE->WADDR->WDATA->WRESP->IDLE; read path IDLE->RADDR->RDATA->IDLE.
REQ-006 At the edge sampling user_start_0=1 in IDLE, SHALL latch addr, len, strb and w_r; on a write also latch user_data_in_0 as beat 0; user_free_0 SHALL be 0 from that edge.
REQ-007 WADDR: AWVALID held until AWREADY; then WDATA. AW and W are sequential, never concurrent.
REQ-008 WDATA: WVALID with held word, WSTRB=latched strb, WLAST on beat LEN; after each W handshake (including the last) user_stall_w_data_0 SHALL be 0 for exactly one cycle; next beat captured from user_data_in_0 at the following edge.
REQ-009 user_stall_w_data_0 SHALL be 1 during a write from command acceptance to BVALID, except in REQ-008 one-cycle windows; 0 in IDLE and during reads.
REQ-010 WRESP: BREADY=1; on B handshake latch BRESP into user_status_0, return to IDLE, user_free_0=1 at the next edge.
REQ-011 RADDR: ARVALID until ARREADY. RDATA: RREADY=1; each R handshake registers RDATA to user_data_out_0 and sets user_data_out_en_0=1 for one cycle; on RLAST, status = worst RRESP of the burst, return to IDLE.
REQ-012 user_data_out_en_0 SHALL be 0 for at least one cycle between bursts.
REQ-013 user_start_0 outside IDLE SHALL be ignored.
REQ-014 Slave SHALL store MEM_DEPTH words indexed by addr[log2(MEM_DEPTH)+2:3] (addr[12:3] at defaults), incrementing per beat and wrapping modulo MEM_DEPTH; higher address bits ignored (aliasing).
REQ-015 Slave SHALL apply WSTRB per byte: strb bit i writes byte i (bits 8i+7:8i); unstrobed bytes unchanged.
REQ-016 Slave: AWREADY/ARREADY one cycle after VALID; WREADY=1 during a write burst; BVALID the cycle after WLAST; RVALID beats back-to-back; response always OKAY (2'b00).
REQ-017 Bursts crossing 4 KB are the user's responsibility; no split, no error.

Reset
REQ-018 On areset_0=1, immediately and without clock: FSMs to IDLE; user_free_0=1, user_stall_w_data_0=0, user_data_out_en_0=0, user_data_out_0=0, user_status_0=0; all AXI VALID/READY=0.
REQ-019 Reset mid-burst SHALL abandon the transaction; memory contents are not reset; words already written keep their values.

Structure
REQ-020 Shared package: ADDR_W/DATA_W defaults, AXI response codes, burst/size constants, master state enum.
REQ-021 Wrapper instantiates master and one sub-module axi_mem_slave.

Verification
REQ-022 Write 0x10000000 LEN 0 strb 0xFF data 0xF8F4F2F1, read back -> one user_data_out_en_0 pulse, data 0xF8F4F2F1, status 00.
REQ-023 Write 0x10000080 LEN 15, 16 words on stall falls -> exactly 16 stall fall pulses; 16-beat read returns the words in order.
REQ-024 Write 0x300010C0 LEN 15 strb 0xF0 over memory previously zero -> read gives upper 32 bits of each word, lower 32 bits 0.
REQ-025 Single-beat write strb 0x01 then 0xAA to 0x30001500/0x30001540 -> only byte 0 / bytes 1,3,5,7 change.
REQ-026 Ten mixed writes then ten reads back-to-back, each started when user_free_0=1 -> all strobed bytes match; user_free_0 low within one cycle of every start.
REQ-027 areset_0 asserted mid-write burst -> outputs at reset values immediately; next command completes normally.
